// File: rtl/qclk_trig_sched.sv
// qclk_trig_sched: timed-trigger scheduler referenced to the free-running qubit clock.
// Commands {time, data} are queued in order. The head entry is compared with
// qclk_val every cycle. On an exact match it fires: trig_valid pulses the next
// cycle with trig_data. If its time has already passed it is dropped and late
// pulses instead. Ordering uses the signed modulo difference, so it stays
// correct across a qclk wrap.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   qclk_val          current qclk count
//   cmd_time/data     pushed command timestamp and payload
//   cmd_valid         push request (accepted when cmd_ready)
//   cmd_ready         queue not full (from registered count only)
//   flush             discard all queued entries; beats same-cycle push/pop
//   trig_valid        one-cycle pulse, head released on time
//   trig_data         payload of last released command
//   late              one-cycle pulse, head dropped because its time passed
//   count             number of queued entries
//   busy              count != 0
module qclk_trig_sched #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         qclk_val,
  input  logic [WIDTH-1:0]         cmd_time,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     flush,
  output logic                     trig_valid,
  output logic [DATA_W-1:0]        trig_data,
  output logic                     late,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0]  t;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  entry_t             head;
  logic [WIDTH-1:0]   diff;
  logic               have_head;
  logic               fire;
  logic               drop;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   count_nxt;

  // Status decoded straight from registered occupancy.
  assign cmd_ready = (count != CNT_W'(DEPTH));
  assign busy      = (count != '0);

  // Head evaluation: modulo difference read as signed; MSB set means future.
  assign head      = mem[rd_ptr];
  assign diff      = qclk_val - head.t;
  assign have_head = busy;
  assign fire      = have_head && (diff == '0);
  assign drop      = have_head && (diff != '0) && !diff[WIDTH-1];

  // Flush overrides both queue operations in the same cycle.
  assign push = cmd_valid && cmd_ready && !flush;
  assign pop  = (fire || drop) && !flush;

  // Next occupancy.
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Entry storage; contents beyond count are don't-care, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{t: cmd_time, d: cmd_data};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // Output pulses; trig_data holds its last value between releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_valid <= 1'b0;
      late       <= 1'b0;
      trig_data  <= '0;
    end else begin
      trig_valid <= fire && !flush;
      late       <= drop && !flush;
      if (fire && !flush) trig_data <= head.d;
    end
  end

endmodule

// File: tb/tb_qclk_trig_sched.sv
module tb_qclk_trig_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] qclk_val = '0;
  logic [31:0] cmd_time = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        flush = 1'b0;
  logic        trig_valid;
  logic [15:0] trig_data;
  logic        late;
  logic [2:0]  count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_late;
    logic [15:0] data;
    logic [31:0] q;
  } exp_t;

  exp_t exp_q[$];

  qclk_trig_sched #(.WIDTH(32), .DATA_W(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .qclk_val   (qclk_val),
    .cmd_time   (cmd_time),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .flush      (flush),
    .trig_valid (trig_valid),
    .trig_data  (trig_data),
    .late       (late),
    .count      (count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One cycle: qclk advances with the edge, as the real counter does.
  task automatic step();
    @(posedge clk);
    #1;
    qclk_val = qclk_val + 32'd1;
  endtask

  task automatic push(input logic [31:0] t, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_time  = t;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_trig(input logic [15:0] d, input logic [31:0] q);
    exp_q.push_back('{is_late: 1'b0, data: d, q: q});
  endtask

  task automatic expect_late(input logic [31:0] q);
    exp_q.push_back('{is_late: 1'b1, data: 16'h0, q: q});
  endtask

  // Bounded wait for all expected pulses, then the queue must be empty.
  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step();
      i++;
    end
    step();
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_count"}, 64'(count), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every pulse must match the oldest expectation, including the qclk cycle it lands in.
  always @(negedge clk) begin
    if (!rst) begin
      chk("exclusive", 64'(trig_valid && late), 64'd0);
      if (trig_valid || late) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse trig_valid=%0b late=%0b qclk=%0h", trig_valid, late, qclk_val);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind_late", 64'(late), 64'(e.is_late));
          chk("pulse_qclk", 64'(qclk_val), 64'(e.q));
          if (!e.is_late) chk("trig_data", 64'(trig_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    // Reset state.
    idle(2);
    rst = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_trig_valid", 64'(trig_valid), 64'd0);
    chk("rst_late", 64'(late), 64'd0);
    chk("rst_trig_data", 64'(trig_data), 64'd0);

    // Single on-time trigger.
    qclk_val = 32'd90;
    push(32'd100, 16'h00A5);
    expect_trig(16'h00A5, 32'd101);
    chk("t1_count", 64'(count), 64'd1);
    wait_idle("t1", 40);

    // Fill to DEPTH, extra push ignored, consecutive triggers.
    qclk_val = 32'd190;
    push(32'd200, 16'h0010);
    push(32'd201, 16'h0011);
    push(32'd202, 16'h0012);
    push(32'd203, 16'h0013);
    expect_trig(16'h0010, 32'd201);
    expect_trig(16'h0011, 32'd202);
    expect_trig(16'h0012, 32'd203);
    expect_trig(16'h0013, 32'd204);
    chk("t2_full_count", 64'(count), 64'd4);
    chk("t2_full_ready", 64'(cmd_ready), 64'd0);
    push(32'd205, 16'h00FF);
    chk("t2_ignored_count", 64'(count), 64'd4);
    wait_idle("t2", 40);

    // Late entry dropped, following entry pushed during the pop still fires.
    qclk_val = 32'd60;
    push(32'd50, 16'h0033);
    expect_late(32'd62);
    push(32'd70, 16'h0044);
    chk("t3_count", 64'(count), 64'd1);
    expect_trig(16'h0044, 32'd71);
    wait_idle("t3", 40);

    // Wrap across 2^32.
    qclk_val = 32'hFFFF_FFFE;
    push(32'h0000_0002, 16'h0055);
    expect_trig(16'h0055, 32'h0000_0003);
    wait_idle("t4", 20);

    // Duplicate timestamp: second one is late.
    qclk_val = 32'd295;
    push(32'd300, 16'h0066);
    push(32'd300, 16'h0077);
    expect_trig(16'h0066, 32'd301);
    expect_late(32'd302);
    wait_idle("t5", 20);
    chk("t5_trig_data_hold", 64'(trig_data), 64'h0066);

    // Flush with simultaneous push: all gone, no pulses afterwards.
    qclk_val = 32'd400;
    push(32'd500, 16'h0001);
    push(32'd501, 16'h0002);
    push(32'd502, 16'h0003);
    chk("t6_pre_count", 64'(count), 64'd3);
    flush = 1'b1;
    push(32'd503, 16'h0004);
    flush = 1'b0;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_ready", 64'(cmd_ready), 64'd1);
    idle(110);

    // Flush in the same cycle the head fires: no pulse.
    qclk_val = 32'd698;
    push(32'd700, 16'h0088);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t7_count", 64'(count), 64'd0);
    idle(5);

    // Reset mid-queue.
    qclk_val = 32'd590;
    push(32'd600, 16'h0099);
    push(32'd601, 16'h009A);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t8_count", 64'(count), 64'd0);
    chk("t8_busy", 64'(busy), 64'd0);
    chk("t8_ready", 64'(cmd_ready), 64'd1);
    chk("t8_trig_valid", 64'(trig_valid), 64'd0);
    chk("t8_late", 64'(late), 64'd0);
    chk("t8_trig_data", 64'(trig_data), 64'd0);
    idle(20);

    chk("final_pending", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
